// File: rtl/oric_kbd_matrix.sv
// PS/2 set-2 key events to Oric 8x8 keyboard matrix, with minimum-press hold-off,
// registered row/column sense and an F11 level NMI request.
module oric_kbd_matrix #(
  parameter int HOLD_CYCLES = 480000,
  parameter int CNT_W       = 20
) (
  input  logic       clk_in,
  input  logic       RESET,
  input  logic       key_strobe,
  input  logic       key_pressed,
  input  logic       key_extended,
  input  logic [7:0] key_code,
  input  logic [2:0] row_sel,
  input  logic [7:0] col_mask,
  output logic       key_sense,
  output logic       any_key,
  output logic       key_nmi
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);

  // Returns {valid, row[2:0], col[2:0]}
  function automatic logic [6:0] lookup(input logic ext, input logic [7:0] code);
    logic [6:0] r;
    r = 7'd0;
    case ({ext, code})
      9'h029: r = {1'b1, 3'd0, 3'd0};  // space
      9'h031: r = {1'b1, 3'd0, 3'd1};  // N
      9'h02E: r = {1'b1, 3'd0, 3'd2};  // 5
      9'h02A: r = {1'b1, 3'd0, 3'd3};  // V
      9'h016: r = {1'b1, 3'd0, 3'd5};  // 1
      9'h022: r = {1'b1, 3'd0, 3'd6};  // X
      9'h026: r = {1'b1, 3'd0, 3'd7};  // 3
      9'h03B: r = {1'b1, 3'd1, 3'd0};  // J
      9'h02C: r = {1'b1, 3'd1, 3'd1};  // T
      9'h02D: r = {1'b1, 3'd1, 3'd2};  // R
      9'h02B: r = {1'b1, 3'd1, 3'd3};  // F
      9'h076: r = {1'b1, 3'd1, 3'd5};  // ESC
      9'h015: r = {1'b1, 3'd1, 3'd6};  // Q
      9'h023: r = {1'b1, 3'd1, 3'd7};  // D
      9'h03A: r = {1'b1, 3'd2, 3'd0};  // M
      9'h036: r = {1'b1, 3'd2, 3'd1};  // 6
      9'h032: r = {1'b1, 3'd2, 3'd2};  // B
      9'h025: r = {1'b1, 3'd2, 3'd3};  // 4
      9'h014: r = {1'b1, 3'd2, 3'd4};  // CTRL
      9'h01A: r = {1'b1, 3'd2, 3'd5};  // Z
      9'h01E: r = {1'b1, 3'd2, 3'd6};  // 2
      9'h021: r = {1'b1, 3'd2, 3'd7};  // C
      9'h042: r = {1'b1, 3'd3, 3'd0};  // K
      9'h046: r = {1'b1, 3'd3, 3'd1};  // 9
      9'h04C: r = {1'b1, 3'd3, 3'd2};  // ;
      9'h04E: r = {1'b1, 3'd3, 3'd3};  // -
      9'h05D: r = {1'b1, 3'd3, 3'd6};  // backslash
      9'h052: r = {1'b1, 3'd3, 3'd7};  // quote
      9'h03D: r = {1'b1, 3'd4, 3'd0};  // 7
      9'h041: r = {1'b1, 3'd4, 3'd1};  // ,
      9'h049: r = {1'b1, 3'd4, 3'd2};  // .
      9'h175: r = {1'b1, 3'd4, 3'd3};  // up
      9'h012: r = {1'b1, 3'd4, 3'd4};  // left shift
      9'h16B: r = {1'b1, 3'd4, 3'd5};  // left
      9'h172: r = {1'b1, 3'd4, 3'd6};  // down
      9'h174: r = {1'b1, 3'd4, 3'd7};  // right
      9'h03C: r = {1'b1, 3'd5, 3'd0};  // U
      9'h043: r = {1'b1, 3'd5, 3'd1};  // I
      9'h044: r = {1'b1, 3'd5, 3'd2};  // O
      9'h04D: r = {1'b1, 3'd5, 3'd3};  // P
      9'h011: r = {1'b1, 3'd5, 3'd4};  // FUNCT on left alt
      9'h066: r = {1'b1, 3'd5, 3'd5};  // DEL on backspace
      9'h05B: r = {1'b1, 3'd5, 3'd6};  // ]
      9'h054: r = {1'b1, 3'd5, 3'd7};  // [
      9'h035: r = {1'b1, 3'd6, 3'd0};  // Y
      9'h033: r = {1'b1, 3'd6, 3'd1};  // H
      9'h034: r = {1'b1, 3'd6, 3'd2};  // G
      9'h024: r = {1'b1, 3'd6, 3'd3};  // E
      9'h01C: r = {1'b1, 3'd6, 3'd5};  // A
      9'h01B: r = {1'b1, 3'd6, 3'd6};  // S
      9'h01D: r = {1'b1, 3'd6, 3'd7};  // W
      9'h03E: r = {1'b1, 3'd7, 3'd0};  // 8
      9'h04B: r = {1'b1, 3'd7, 3'd1};  // L
      9'h045: r = {1'b1, 3'd7, 3'd2};  // 0
      9'h04A: r = {1'b1, 3'd7, 3'd3};  // /
      9'h059: r = {1'b1, 3'd7, 3'd4};  // right shift
      9'h05A: r = {1'b1, 3'd7, 3'd5};  // return
      9'h055: r = {1'b1, 3'd7, 3'd7};  // =
      default: r = 7'd0;
    endcase
    return r;
  endfunction

  logic [63:0]      matrix, pending;
  logic [63:0]      matrix_nxt, pend_nxt, onehot;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [6:0]       lk;
  logic             hit, f11, expire;
  logic [7:0]       row_bits;

  always_comb begin
    lk         = lookup(key_extended, key_code);
    hit        = key_strobe && lk[6];
    f11        = key_strobe && !key_extended && (key_code == 8'h78);
    onehot     = 64'd1 << lk[5:0];
    expire     = (hold_cnt == CNT_W'(1));
    matrix_nxt = matrix;
    pend_nxt   = pending;
    cnt_nxt    = hold_cnt;
    if (hold_cnt != '0) cnt_nxt = hold_cnt - CNT_W'(1);
    if (expire) begin
      matrix_nxt = matrix & ~pending;
      pend_nxt   = '0;
    end
    if (hit) begin
      if (key_pressed) begin
        matrix_nxt = matrix_nxt | onehot;
        pend_nxt   = pend_nxt & ~onehot;
        cnt_nxt    = HOLD_LD;
      end else if (hold_cnt == '0 || expire) begin
        // A break landing on the expiry edge is folded into that edge's clear.
        matrix_nxt = matrix_nxt & ~onehot;
      end else begin
        pend_nxt = pend_nxt | onehot;
      end
    end
    row_bits = matrix[{row_sel, 3'b000} +: 8];
  end

  always_ff @(posedge clk_in) begin
    if (RESET) begin
      matrix    <= '0;
      pending   <= '0;
      hold_cnt  <= '0;
      key_sense <= 1'b0;
      any_key   <= 1'b0;
      key_nmi   <= 1'b0;
    end else begin
      matrix    <= matrix_nxt;
      pending   <= pend_nxt;
      hold_cnt  <= cnt_nxt;
      key_sense <= |(row_bits & ~col_mask);
      any_key   <= |matrix;
      if (f11) key_nmi <= key_pressed;
    end
  end

endmodule

// File: doc/oric_kbd_matrix.md
Name: oric_kbd_matrix

Overview:
- Sits between user_io's PS/2 key event stream and the oricatmos core.
- Turns PS/2 set-2 make/break events into a 64-key Oric keyboard matrix (8 rows x 8 columns).
- Answers the core's row/column scan with a registered key-sense bit.
- Holds every key down for at least HOLD_CYCLES, so a fast tap is not missed by the ROM's interrupt-driven scan. Also drives a level NMI request from F11.

Parameters:
HOLD_CYCLES, 480000, minimum press duration in clk_in cycles (20 ms at 24 MHz); 0 disables hold-off
CNT_W, 20, width of hold counter; must satisfy 2^CNT_W > HOLD_CYCLES

Ports:
clk_in  input  1  system clock (24 MHz)
RESET  input  1  synchronous, active-high reset
key_strobe  input  1  one-cycle pulse: key event valid this cycle
key_pressed  input  1  1 = make, 0 = break (qualified by key_strobe)
key_extended  input  1  E0-prefixed scancode (qualified by key_strobe)
key_code  input  8  PS/2 set-2 scancode (qualified by key_strobe)
row_sel  input  3  keyboard row selected by the VIA port B bits 2:0
col_mask  input  8  column enables from PSG port A, active low (0 = column scanned)
key_sense  output  1  1 = some pressed key lies in the selected row within the enabled columns
any_key  output  1  1 = at least one matrix bit set
key_nmi  output  1  high while F11 (0x78, non-extended) is held

Behaviour:
- Clocking and reset:
  - Single clock domain: clk_in.
  - RESET is synchronous and active-high.
  - On RESET, all of the following are 0: the matrix (64 bits), the pending-release mask (64 bits), the hold counter, key_sense, any_key and key_nmi.
  - RESET mid-hold discards all pending releases; no deferred clear fires afterwards.
- Lookup:
  - A combinational table maps {key_extended, key_code} to {valid, row[2:0], col[2:0]}.
  - Normative entries:
    - 0x29 space -> r0 c0
    - 0x1C A -> r6 c5
    - 0x12 LShift -> r4 c4
    - 0x59 RShift -> r7 c4
    - E0 0x75 Up -> r4 c3
    - E0 0x72 Down -> r4 c6
    - 0x5A Return -> r7 c5
  - The remaining Oric keys are listed in the table include.
  - Unmapped codes change no state, except for the F11 handling below.
- Event on key_strobe=1 with a valid mapping, index k = row*8+col:
  - make:
    - matrix[k] <= 1 and pending[k] <= 0.
    - Hold counter <= HOLD_CYCLES; it reloads even if already running.
  - break, counter == 0: matrix[k] <= 0 on the next edge.
  - break, counter != 0: pending[k] <= 1; matrix[k] stays 1.
- F11 non-extended: make sets key_nmi, break clears it. No matrix effect and no hold-off.
- Hold counter:
  - Decrements by 1 each cycle while nonzero.
  - In the cycle where counter == 1 (the expiry edge), matrix <= matrix & ~pending and pending <= 0.
- Simultaneous events:
  - A break for key k in the expiry cycle is merged: matrix[k] is cleared on that same edge.
  - A make in the expiry cycle wins over expiry for its key: matrix[k]=1 and pending[k]=0.
  - That make also reloads the counter, so the expiry clear is applied to the other pending bits only.
- HOLD_CYCLES=0: the counter never becomes nonzero, so every break clears immediately.
- Multiple keys may be held; there is no ghosting or blocking model.
- key_sense is registered, 1-cycle latency:
  - key_sense <= OR over c of (matrix[row_sel*8+c] & ~col_mask[c]).
  - It uses the matrix value before the current edge's update, so a key change becomes visible 2 edges after its strobe.
  - col_mask = 0xFF gives key_sense = 0.
- any_key is registered: any_key <= |matrix, with the same latency as key_sense.
- Inputs other than the key event are sampled only as described above; key_code and key_extended are ignored when key_strobe=0.

Test Plan:
- Tap with no hold-off:
  - HOLD_CYCLES=0. Make 0x1C, then break 0x1C 5 cycles later; row_sel=6, col_mask=0xDF.
  - Required: key_sense=1 from the 2nd edge after the make until the 2nd edge after the break, then 0.
- Hold-off stretch:
  - HOLD_CYCLES=100. Make 0x29, then break 0x29 after 10 cycles; row_sel=0, col_mask=0xFE.
  - Required: key_sense stays 1 until 100 cycles after the make (+1 latency), then 0; pending is empty afterwards.
- Re-press during pending:
  - HOLD_CYCLES=100. Make, break, then make of 0x59 at cycles 0/10/50.
  - Required: r7c4 stays set past cycle 100 and past cycle 150; a later break with counter 0 clears it on the next edge.
- Expiry collision:
  - Make A at cycle 0; make space at cycle 5 (counter reloads); break A at cycle 10; break space in exactly the expiry cycle (counter==1).
  - Required: both bits clear on that edge; any_key=0 one cycle later.
- Column masking and extended keys:
  - Hold E0 0x75 and LShift (both r4); col_mask=0xF7.
  - Required: key_sense=1 from c3 only. col_mask=0xFF gives key_sense=0. The non-extended code 0x75 (keypad 8, unmapped) changes nothing.
- Reset mid-hold and NMI:
  - Hold F11 and A with HOLD_CYCLES=100, then release A.
  - Assert RESET at cycle 20, deassert at cycle 21.
  - Required: key_nmi=0, any_key=0 and key_sense=0 after reset, and no state changes at cycle 100.
